// File: rtl/acq_core_ctrl_if.sv
// ============================================================================
//  Module      : core_interface
//  Description : Sequencer <-> correlator core handshake bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface core_interface;
    logic we;
    logic data_latch;
    logic we_adder;
    logic code_load;
    logic wr_buf;
    logic valid;

    modport slave  (output we, output data_latch, output we_adder,
                    output code_load, output wr_buf, input valid);
    modport master (input we, input data_latch, input we_adder,
                    input code_load, input wr_buf, output valid);
endinterface

`default_nettype wire

// File: rtl/acq_core_ctrl.sv
// ============================================================================
//  Module      : acq_core_ctrl
//  Description : Fill / correlate / drain sequencer for one correlator core.
//                Optional drain watchdog: define ACQ_CTRL_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module acq_core_ctrl #(
    parameter int CORE_SIZE = 256,
    parameter int N_SHIFTS  = 64,
    parameter int N_BLOCKS  = 4,
    parameter int ADDER_LAT = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     smp_vld,
    core_interface.slave                             core_if,
    output logic                                     busy,
    output logic                                     done,
    output logic [$clog2(N_SHIFTS*N_BLOCKS+1)-1:0]   res_cnt,
    output logic                                     err
);

    localparam int c_TOTAL   = N_SHIFTS * N_BLOCKS;
    localparam int c_RES_W   = $clog2(c_TOTAL + 1);
    localparam int c_FILL_W  = (CORE_SIZE > 1) ? $clog2(CORE_SIZE) : 1;
    localparam int c_SHIFT_W = (N_SHIFTS  > 1) ? $clog2(N_SHIFTS)  : 1;
    localparam int c_BLK_W   = (N_BLOCKS  > 1) ? $clog2(N_BLOCKS)  : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_CORR   = 3'd2,
        S_RELOAD = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    generate
        if (ADDER_LAT != $clog2(CORE_SIZE) || TIMEOUT < 2) begin : g_param_check
            $error("acq_core_ctrl: ADDER_LAT must equal clog2(CORE_SIZE) and TIMEOUT >= 2");
        end
    endgenerate

    state_t                 r_state;
    logic [c_FILL_W-1:0]    r_fill_cnt;
    logic [c_SHIFT_W-1:0]   r_shift_cnt;
    logic [c_BLK_W-1:0]     r_blk_cnt;
    logic [c_RES_W-1:0]     r_res_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_loaded;

    logic                   w_acc;
    logic                   w_fill_last;
    logic                   w_shift_last;
    logic                   w_blk_last;
    logic                   w_res_inc;
    logic [c_RES_W-1:0]     w_res_next;
    logic                   w_res_full;

    // Strobes are masked during reset so an abort never leaks a partial load.
    assign w_acc        = smp_vld & ~rst;
    assign w_fill_last  = (r_fill_cnt  == c_FILL_W'(CORE_SIZE - 1));
    assign w_shift_last = (r_shift_cnt == c_SHIFT_W'(N_SHIFTS - 1));
    assign w_blk_last   = (r_blk_cnt   == c_BLK_W'(N_BLOCKS - 1));

    assign core_if.we         = ((r_state == S_FILL) || (r_state == S_CORR)) && w_acc;
    assign core_if.we_adder   = (r_state == S_CORR) && w_acc;
    assign core_if.data_latch = (r_state == S_FILL) && w_acc && w_fill_last;
    assign core_if.wr_buf     = core_if.data_latch && !r_loaded;
    assign core_if.code_load  = (r_state == S_RELOAD) && !rst;

    assign w_res_inc  = core_if.valid && (r_state != S_IDLE) && (r_res_cnt != c_RES_W'(c_TOTAL));
    assign w_res_next = r_res_cnt + c_RES_W'(w_res_inc);
    assign w_res_full = (w_res_next == c_RES_W'(c_TOTAL));

    assign busy    = r_busy;
    assign done    = r_done;
    assign res_cnt = r_res_cnt;

`ifdef ACQ_CTRL_TIMEOUT_EN
    localparam int c_DRN_W = $clog2(TIMEOUT);
    logic [c_DRN_W-1:0] r_drain_cnt;
    logic               r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fill_cnt  <= '0;
            r_shift_cnt <= '0;
            r_blk_cnt   <= '0;
            r_res_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_loaded    <= 1'b0;
`ifdef ACQ_CTRL_TIMEOUT_EN
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_res_cnt <= w_res_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FILL;
                        r_busy      <= 1'b1;
                        r_fill_cnt  <= '0;
                        r_shift_cnt <= '0;
                        r_blk_cnt   <= '0;
                        r_res_cnt   <= '0;
`ifdef ACQ_CTRL_TIMEOUT_EN
                        r_drain_cnt <= '0;
                        r_err       <= 1'b0;
`endif
                    end
                end
                S_FILL: begin
                    if (w_acc) begin
                        if (w_fill_last) begin
                            r_fill_cnt <= '0;
                            r_loaded   <= 1'b1;
                            r_state    <= S_CORR;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 1'b1;
                        end
                    end
                end
                S_CORR: begin
                    if (w_acc) begin
                        if (w_shift_last) begin
                            r_shift_cnt <= '0;
                            r_state     <= w_blk_last ? S_DRAIN : S_RELOAD;
                        end else begin
                            r_shift_cnt <= r_shift_cnt + 1'b1;
                        end
                    end
                end
                S_RELOAD: begin
                    r_blk_cnt <= r_blk_cnt + 1'b1;
                    r_state   <= S_CORR;
                end
                S_DRAIN: begin
                    if (w_res_full) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
`ifdef ACQ_CTRL_TIMEOUT_EN
                    else if (r_drain_cnt == c_DRN_W'(TIMEOUT - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_acq_core_ctrl.sv
// ============================================================================
//  Module      : tb_acq_core_ctrl
//  Description : Randomized self-checking bench for acq_core_ctrl with a core
//                latency model and a sample-count based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_acq_core_ctrl;

    localparam int CORE_SIZE = 8;
    localparam int N_SHIFTS  = 4;
    localparam int N_BLOCKS  = 2;
    localparam int ADDER_LAT = 3;
    localparam int TIMEOUT   = 16;
    localparam int TOTAL     = N_SHIFTS * N_BLOCKS;
    localparam int TOT_SMP   = CORE_SIZE + TOTAL;
    localparam int RES_W     = $clog2(TOTAL + 1);
    localparam int MAXT      = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             smp_vld = 1'b0;
    logic             busy;
    logic             done;
    logic             err;
    logic [RES_W-1:0] res_cnt;
    logic             kill_valid = 1'b0;
    logic [ADDER_LAT-1:0] r_pipe = '0;

    int n_chk = 0;
    int n_err = 0;

    bit v    [MAXT];
    bit e_we [MAXT];
    bit e_wa [MAXT];
    bit e_cl [MAXT];
    bit e_dl [MAXT];
    int e_done;
    int e_lastwa;

    core_interface u_cif ();

    acq_core_ctrl #(
        .CORE_SIZE (CORE_SIZE),
        .N_SHIFTS  (N_SHIFTS),
        .N_BLOCKS  (N_BLOCKS),
        .ADDER_LAT (ADDER_LAT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .smp_vld (smp_vld),
        .core_if (u_cif.slave),
        .busy    (busy),
        .done    (done),
        .res_cnt (res_cnt),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Core model: every we_adder returns a valid ADDER_LAT cycles later.
    always @(posedge clk) r_pipe <= {r_pipe[ADDER_LAT-2:0], u_cif.we_adder};
    assign u_cif.valid = r_pipe[ADDER_LAT-1] & ~kill_valid;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Walk accepted samples: CORE_SIZE fill samples, then N_BLOCKS groups of
    // N_SHIFTS correlation samples with one sample-less reload cycle between.
    task automatic build_model(input int mode, input int kill);
        int n;
        int t;
        bit reload_next;
        for (int i = 0; i < MAXT; i++) begin
            case (mode)
                0:       v[i] = 1'b1;
                1:       v[i] = (i % 2) == 1;
                default: v[i] = (i >= 150) ? 1'b1 : ($urandom_range(0, 99) < 60);
            endcase
            e_we[i] = 0; e_wa[i] = 0; e_cl[i] = 0; e_dl[i] = 0;
        end
        n = 0; t = 1; reload_next = 0; e_lastwa = 0;
        while (n < TOT_SMP && t < MAXT) begin
            if (reload_next) begin
                e_cl[t] = 1;
                reload_next = 0;
            end else if (v[t]) begin
                e_we[t] = 1;
                if (n >= CORE_SIZE) begin
                    e_wa[t] = 1;
                    e_lastwa = t;
                end
                if (n == CORE_SIZE - 1) e_dl[t] = 1;
                n++;
                if (n > CORE_SIZE && ((n - CORE_SIZE) % N_SHIFTS) == 0 && n < TOT_SMP)
                    reload_next = 1;
            end
            t++;
        end
        if (kill == 0) begin
            e_done = e_lastwa + ADDER_LAT + 1;
        end else begin
`ifdef ACQ_CTRL_TIMEOUT_EN
            e_done = e_lastwa + 1 + TIMEOUT;
`else
            e_done = -1;
`endif
        end
    endtask

    task automatic run_case(input string name, input int mode, input int exp_wb,
                            input int glitch_t, input int kill);
        int limit;
        int n_pat, n_we, n_wa, n_cl, n_dl, n_wb, n_zero, n_busy, n_done;
        int done_at, res_at, err_at, err_first;
        bit exp_busy;
        build_model(mode, kill);
        kill_valid = (kill != 0);
        limit = ((e_done > 0) ? e_done : (e_lastwa + 1 + TIMEOUT + 20)) + 3;
        n_pat = 0; n_we = 0; n_wa = 0; n_cl = 0; n_dl = 0; n_wb = 0;
        n_zero = 0; n_busy = 0; n_done = 0; done_at = -1; res_at = -1; err_at = -1; err_first = -1;
        @(negedge clk);
        start = 1'b1;
        smp_vld = 1'b0;
        for (int t = 1; t <= limit; t++) begin
            @(negedge clk);
            start = (t == glitch_t);
            smp_vld = v[t];
            #1;
            if ({u_cif.we, u_cif.we_adder, u_cif.code_load, u_cif.data_latch} !==
                {e_we[t], e_wa[t], e_cl[t], e_dl[t]}) n_pat++;
            n_we += int'(u_cif.we);
            n_wa += int'(u_cif.we_adder);
            n_cl += int'(u_cif.code_load);
            n_dl += int'(u_cif.data_latch);
            n_wb += int'(u_cif.wr_buf);
            if (!smp_vld && (u_cif.we || u_cif.we_adder || u_cif.data_latch || u_cif.wr_buf))
                n_zero++;
            exp_busy = (e_done < 0) ? 1'b1 : (t < e_done);
            if (busy !== exp_busy) n_busy++;
            if (t == 1) err_first = int'(err);
            if (done) begin
                n_done++;
                done_at = t;
                res_at = int'(res_cnt);
                err_at = int'(err);
            end
        end
        start = 1'b0;
        smp_vld = 1'b0;
        check({name, " strobe_pattern_errs"}, n_pat, 0);
        check({name, " we_count"}, n_we, TOT_SMP);
        check({name, " we_adder_count"}, n_wa, TOTAL);
        check({name, " code_load_count"}, n_cl, N_BLOCKS - 1);
        check({name, " data_latch_count"}, n_dl, 1);
        check({name, " wr_buf_count"}, n_wb, exp_wb);
        check({name, " strobes_while_idle_input"}, n_zero, 0);
        check({name, " busy_errs"}, n_busy, 0);
        check({name, " err_after_start"}, err_first, 0);
        if (e_done < 0) begin
            check({name, " done_count"}, n_done, 0);
        end else begin
            check({name, " done_count"}, n_done, 1);
            check({name, " done_cycle"}, done_at, e_done);
            check({name, " res_cnt_at_done"}, res_at, (kill != 0) ? 0 : TOTAL);
            check({name, " err_at_done"}, err_at, (kill != 0) ? 1 : 0);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, " busy"}, int'(busy), 0);
        check({name, " done"}, int'(done), 0);
        check({name, " res_cnt"}, int'(res_cnt), 0);
        check({name, " strobes"}, int'({u_cif.we, u_cif.we_adder, u_cif.code_load,
                                        u_cif.data_latch, u_cif.wr_buf}), 0);
    endtask

    initial begin
        rst = 1'b1;
        smp_vld = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset err", int'(err), 0);

        // start and rst together: reset must win
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        #1;
        check_quiet("start_with_rst");
        smp_vld = 1'b0;
        repeat (2) @(negedge clk);

        run_case("full_rate", 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        run_case("toggle", 1, 0, 20, 0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            run_case($sformatf("random%0d", k), 2, 0, 0, 0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // abort mid-CORR with one reset cycle
        @(negedge clk);
        start = 1'b1;
        smp_vld = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (t == 11);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("after_abort");
        repeat (4) @(negedge clk);
        #1;
        check("late_valid_ignored res_cnt", int'(res_cnt), 0);
        smp_vld = 1'b0;
        run_case("after_abort_run", 0, 1, 0, 0);
        repeat (3) @(negedge clk);

        run_case("no_valid", 0, 0, 0, 1);
        kill_valid = 1'b0;
`ifdef ACQ_CTRL_TIMEOUT_EN
        repeat (2) @(negedge clk);
        #1;
        check("err_sticky", int'(err), 1);
        run_case("post_timeout", 2, 0, 0, 0);
`else
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_case("post_hang", 1, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
